// File: rtl/sal_cmd_pkg.sv
// Shared command-generator types: command enum, DDR2 pin encodings, burst descriptor.
// Descriptor fields are sized by SAL_ID_W / SAL_LEN_W; wider module parameters are truncated.
package sal_cmd_pkg;

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_ACT,
      CMD_RD,
      CMD_WR,
      CMD_PRE,
      CMD_REF
   } cmd_e;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] PINS_NOP = 4'b0111;
   localparam logic [3:0] PINS_ACT = 4'b0011;
   localparam logic [3:0] PINS_RD  = 4'b0101;
   localparam logic [3:0] PINS_WR  = 4'b0100;
   localparam logic [3:0] PINS_PRE = 4'b0010;
   localparam logic [3:0] PINS_REF = 4'b0001;

   localparam int SAL_ID_W  = 4;
   localparam int SAL_LEN_W = 4;

   typedef struct packed {
      logic [SAL_ID_W-1:0]  id;
      logic [SAL_LEN_W-1:0] len;
   } burst_desc_t;

   function automatic logic [3:0] cmd_pins(input cmd_e c);
      case (c)
         CMD_ACT: return PINS_ACT;
         CMD_RD:  return PINS_RD;
         CMD_WR:  return PINS_WR;
         CMD_PRE: return PINS_PRE;
         CMD_REF: return PINS_REF;
         default: return PINS_NOP;
      endcase
   endfunction

endpackage

// File: rtl/sal_burst_engine.sv
// Latency pipeline plus beat counter for one data direction.
// A start drops a descriptor into slot lat_i; slot 0 launches the burst one cycle later.
module sal_burst_engine
   import sal_cmd_pkg::*;
#(
   parameter int ID_W  = 4,
   parameter int LEN_W = 4,
   parameter int LAT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [ID_W-1:0]  id_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [LAT_W-1:0] lat_i,
   output logic             data_en_o,
   output logic             last_o,
   output logic [ID_W-1:0]  id_o,
   output logic             pipe_busy_o,
   output logic             overlap_o
);

   localparam int DEPTH = 1 << LAT_W;

   logic [DEPTH-1:0] vld_q, vld_d;
   burst_desc_t      slot_q [DEPTH];
   burst_desc_t      new_desc;
   burst_desc_t      head;
   logic             launch;

   logic             act_q, act_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0]  id_q, id_d;

   assign new_desc.id  = SAL_ID_W'(id_i);
   assign new_desc.len = SAL_LEN_W'(len_i);

   always_comb begin
      vld_d = vld_q >> 1;
      if (start_i) vld_d[lat_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   // Descriptor payload needs no reset: only valid bits qualify it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH - 1; i++) slot_q[i] <= slot_q[i+1];
      if (start_i) slot_q[lat_i] <= new_desc;
   end

   assign head   = slot_q[0];
   assign launch = vld_q[0];

   always_comb begin
      act_d = act_q;
      cnt_d = cnt_q;
      id_d  = id_q;
      if (launch) begin
         act_d = 1'b1;
         cnt_d = LEN_W'(head.len);
         id_d  = ID_W'(head.id);
      end else if (act_q) begin
         if (cnt_q == '0) act_d = 1'b0;
         else             cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= 1'b0;
         cnt_q <= '0;
         id_q  <= '0;
      end else begin
         act_q <= act_d;
         cnt_q <= cnt_d;
         id_q  <= id_d;
      end
   end

   assign data_en_o   = act_q;
   assign last_o      = act_q && (cnt_q == '0);
   assign id_o        = id_q;
   assign pipe_busy_o = |vld_q;
   // Launch on the final beat of the old burst is a legal back-to-back, not an overlap.
   assign overlap_o   = launch && act_q && (cnt_q != '0);

endmodule

// File: rtl/sal_cmd_gen.sv
// DDR2 command generator: grant arbitration, registered command pins, read/write burst timing.
// Optional SAL_CMD_GEN_ODT_EN drives dram_odt around write bursts; otherwise dram_odt is 0.
module sal_cmd_gen
   import sal_cmd_pkg::*;
#(
   parameter int BA_W   = 2,
   parameter int ADDR_W = 14,
   parameter int CA_W   = 10,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 4,
   parameter int LAT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              act_gnt,
   input  logic              rd_gnt,
   input  logic              wr_gnt,
   input  logic              pre_gnt,
   input  logic              ref_gnt,
   input  logic [BA_W-1:0]   ba,
   input  logic [ADDR_W-1:0] ra,
   input  logic [CA_W-1:0]   ca,
   input  logic [ID_W-1:0]   id,
   input  logic [LEN_W-1:0]  len,
   input  logic [LAT_W-1:0]  rl_m1,
   input  logic [LAT_W-1:0]  wl_m1,
   output logic              dram_cs_n,
   output logic              dram_ras_n,
   output logic              dram_cas_n,
   output logic              dram_we_n,
   output logic [BA_W-1:0]   dram_ba,
   output logic [ADDR_W-1:0] dram_addr,
   output logic              dram_odt,
   output logic              wr_data_en,
   output logic              wr_last,
   output logic [ID_W-1:0]   wr_id,
   output logic              rd_data_en,
   output logic              rd_last,
   output logic [ID_W-1:0]   rd_id,
   output logic              busy,
   output logic              err_multi_gnt,
   output logic              err_overlap
);

   cmd_e              cmd_sel;
   logic              multi_gnt;
   logic [3:0]        pins_q, pins_d;
   logic [BA_W-1:0]   ba_q, ba_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_multi_q, err_multi_d;
   logic              err_ovl_q, err_ovl_d;
   logic              rd_start, wr_start;
   logic              rd_pipe_busy, wr_pipe_busy;
   logic              rd_ovl, wr_ovl;

   always_comb begin
      cmd_sel = CMD_NOP;
      if      (act_gnt) cmd_sel = CMD_ACT;
      else if (rd_gnt)  cmd_sel = CMD_RD;
      else if (wr_gnt)  cmd_sel = CMD_WR;
      else if (pre_gnt) cmd_sel = CMD_PRE;
      else if (ref_gnt) cmd_sel = CMD_REF;
   end

   assign multi_gnt = ($countones({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}) > 1);
   assign rd_start  = (cmd_sel == CMD_RD);
   assign wr_start  = (cmd_sel == CMD_WR);

   // Column commands keep A10 low (no auto-precharge); column bits sit below A10.
   always_comb begin
      pins_d      = cmd_pins(cmd_sel);
      ba_d        = '0;
      addr_d      = '0;
      err_multi_d = err_multi_q | multi_gnt;
      err_ovl_d   = err_ovl_q | rd_ovl | wr_ovl;
      case (cmd_sel)
         CMD_ACT: begin
            ba_d   = ba;
            addr_d = ra;
         end
         CMD_RD, CMD_WR: begin
            ba_d   = ba;
            addr_d = ADDR_W'(ca);
         end
         CMD_PRE: ba_d = ba;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pins_q      <= PINS_NOP;
         ba_q        <= '0;
         addr_q      <= '0;
         err_multi_q <= 1'b0;
         err_ovl_q   <= 1'b0;
      end else begin
         pins_q      <= pins_d;
         ba_q        <= ba_d;
         addr_q      <= addr_d;
         err_multi_q <= err_multi_d;
         err_ovl_q   <= err_ovl_d;
      end
   end

   assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = pins_q;
   assign dram_ba       = ba_q;
   assign dram_addr     = addr_q;
   assign err_multi_gnt = err_multi_q;
   assign err_overlap   = err_ovl_q;

   sal_burst_engine #(.ID_W(ID_W), .LEN_W(LEN_W), .LAT_W(LAT_W)) u_rd_eng (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (rd_start),
      .id_i        (id),
      .len_i       (len),
      .lat_i       (rl_m1),
      .data_en_o   (rd_data_en),
      .last_o      (rd_last),
      .id_o        (rd_id),
      .pipe_busy_o (rd_pipe_busy),
      .overlap_o   (rd_ovl)
   );

   sal_burst_engine #(.ID_W(ID_W), .LEN_W(LEN_W), .LAT_W(LAT_W)) u_wr_eng (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (wr_start),
      .id_i        (id),
      .len_i       (len),
      .lat_i       (wl_m1),
      .data_en_o   (wr_data_en),
      .last_o      (wr_last),
      .id_o        (wr_id),
      .pipe_busy_o (wr_pipe_busy),
      .overlap_o   (wr_ovl)
   );

   assign busy = rd_pipe_busy | wr_pipe_busy | rd_data_en | wr_data_en;

`ifdef SAL_CMD_GEN_ODT_EN
   // Registered window: WR pin cycle through one cycle past the final write beat.
   logic odt_q, odt_d;
   assign odt_d = wr_start | wr_pipe_busy | wr_data_en;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) odt_q <= 1'b0;
      else        odt_q <= odt_d;
   end
   assign dram_odt = odt_q;
`else
   assign dram_odt = 1'b0;
`endif

endmodule

// File: tb/tb_sal_cmd_gen.sv
// Scoreboard bench for sal_cmd_gen: expected data beats queued at grant time, checked every cycle.
module tb_sal_cmd_gen;

   localparam int BA_W = 2, ADDR_W = 14, CA_W = 10, ID_W = 4, LEN_W = 4, LAT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic act_gnt = 0, rd_gnt = 0, wr_gnt = 0, pre_gnt = 0, ref_gnt = 0;
   logic [BA_W-1:0]   ba = '0;
   logic [ADDR_W-1:0] ra = '0;
   logic [CA_W-1:0]   ca = '0;
   logic [ID_W-1:0]   id = '0;
   logic [LEN_W-1:0]  len = '0;
   logic [LAT_W-1:0]  rl_m1 = '0, wl_m1 = '0;
   logic dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_odt;
   logic [BA_W-1:0]   dram_ba;
   logic [ADDR_W-1:0] dram_addr;
   logic wr_data_en, wr_last, rd_data_en, rd_last, busy, err_multi_gnt, err_overlap;
   logic [ID_W-1:0] wr_id, rd_id;

   sal_cmd_gen dut (
      .clk(clk), .rst_n(rst_n),
      .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
      .ba(ba), .ra(ra), .ca(ca), .id(id), .len(len), .rl_m1(rl_m1), .wl_m1(wl_m1),
      .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n), .dram_we_n(dram_we_n),
      .dram_ba(dram_ba), .dram_addr(dram_addr), .dram_odt(dram_odt),
      .wr_data_en(wr_data_en), .wr_last(wr_last), .wr_id(wr_id),
      .rd_data_en(rd_data_en), .rd_last(rd_last), .rd_id(rd_id),
      .busy(busy), .err_multi_gnt(err_multi_gnt), .err_overlap(err_overlap)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int             c;
      logic [ID_W-1:0] bid;
      logic           last;
   } beat_t;

   beat_t rd_q[$];
   beat_t wr_q[$];
   bit    mon_en = 0;
   bit    exp_rd, exp_wr;
   beat_t b_rd, b_wr;

   // Every cycle: data enable must match the scoreboard; popped beats check id and last.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_rd = (rd_q.size() > 0) && (rd_q[0].c == cyc);
         n_cmp++;
         if (rd_data_en !== exp_rd) begin
            n_err++;
            $display("FAIL rd_data_en cyc=%0d got=%b exp=%b", cyc, rd_data_en, exp_rd);
         end
         if (exp_rd) begin
            b_rd = rd_q.pop_front();
            n_cmp++;
            if (rd_id !== b_rd.bid || rd_last !== b_rd.last) begin
               n_err++;
               $display("FAIL rd_beat cyc=%0d got id=%0d last=%b exp id=%0d last=%b",
                        cyc, rd_id, rd_last, b_rd.bid, b_rd.last);
            end
         end else if (rd_last !== 1'b0) begin
            n_err++;
            $display("FAIL rd_last_idle cyc=%0d got=%b exp=0", cyc, rd_last);
         end
         exp_wr = (wr_q.size() > 0) && (wr_q[0].c == cyc);
         n_cmp++;
         if (wr_data_en !== exp_wr) begin
            n_err++;
            $display("FAIL wr_data_en cyc=%0d got=%b exp=%b", cyc, wr_data_en, exp_wr);
         end
         if (exp_wr) begin
            b_wr = wr_q.pop_front();
            n_cmp++;
            if (wr_id !== b_wr.bid || wr_last !== b_wr.last) begin
               n_err++;
               $display("FAIL wr_beat cyc=%0d got id=%0d last=%b exp id=%0d last=%b",
                        cyc, wr_id, wr_last, b_wr.bid, b_wr.last);
            end
         end else if (wr_last !== 1'b0) begin
            n_err++;
            $display("FAIL wr_last_idle cyc=%0d got=%b exp=0", cyc, wr_last);
         end
      end
   end

   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Call only from the posedge side of cycle c, or with c later than the current cycle.
   task automatic sample_at(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic grant(input int k);
      case (k)
         0: act_gnt = 1'b1;
         1: rd_gnt  = 1'b1;
         2: wr_gnt  = 1'b1;
         3: pre_gnt = 1'b1;
         default: ref_gnt = 1'b1;
      endcase
      @(posedge clk);
      #1;
      {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = '0;
   endtask

   task automatic push_beats(input bit is_rd, input int first, input logic [ID_W-1:0] bid,
                             input int nbeats, input bit ends);
      beat_t b;
      for (int i = 0; i < nbeats; i++) begin
         b.c    = first + i;
         b.bid  = bid;
         b.last = ends && (i == nbeats - 1);
         if (is_rd) rd_q.push_back(b);
         else       wr_q.push_back(b);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} !== 4'b0111) begin
         n_err++;
         $display("FAIL reset_pins got=%b exp=0111", {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n});
      end
      n_cmp++;
      if (dram_ba !== '0 || dram_addr !== '0) begin
         n_err++;
         $display("FAIL reset_ba_addr got ba=%0h addr=%0h exp 0/0", dram_ba, dram_addr);
      end
      n_cmp++;
      if ({dram_odt, wr_data_en, wr_last, rd_data_en, rd_last, busy, err_multi_gnt, err_overlap} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_flags got=%b exp=00000000",
                  {dram_odt, wr_data_en, wr_last, rd_data_en, rd_last, busy, err_multi_gnt, err_overlap});
      end
      n_cmp++;
      if ({wr_id, rd_id} !== '0) begin
         n_err++;
         $display("FAIL reset_ids got wr=%0d rd=%0d exp 0/0", wr_id, rd_id);
      end
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_act;
      int n;
      n = cyc + 2;
      at_cycle(n);
      ba = 2'd2;
      ra = 14'h1A3;
      grant(0);
      sample_at(n + 1);
      n_cmp++;
      if ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, dram_addr} !== {4'b0011, 2'd2, 14'h1A3}) begin
         n_err++;
         $display("FAIL act_pins got=%b ba=%0d addr=%0h exp=0011 ba=2 addr=1a3",
                  {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}, dram_ba, dram_addr);
      end
      sample_at(n + 2);
      n_cmp++;
      if ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, dram_addr} !== {4'b0111, 2'd0, 14'h0}) begin
         n_err++;
         $display("FAIL act_then_nop got=%b ba=%0d addr=%0h exp=0111 ba=0 addr=0",
                  {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}, dram_ba, dram_addr);
      end
   endtask

   task automatic test_encoding;
      logic [3:0]        exp_pins [4] = '{4'b0101, 4'b0100, 4'b0010, 4'b0001};
      logic [BA_W-1:0]   exp_ba   [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
      logic [ADDR_W-1:0] exp_addr [4] = '{14'h3FF, 14'h3FF, 14'h0, 14'h0};
      int n;
      for (int k = 0; k < 4; k++) begin
         n = cyc + 3;
         at_cycle(n);
         ba = 2'd1; ra = 14'h2A5A; ca = 10'h3FF; id = 4'(k + 1); len = '0;
         rl_m1 = 4'd1; wl_m1 = 4'd1;
         if (k == 0) push_beats(1'b1, n + 3, 4'(k + 1), 1, 1'b1);
         if (k == 1) push_beats(1'b0, n + 3, 4'(k + 1), 1, 1'b1);
         grant(k + 1);
         sample_at(n + 1);
         n_cmp++;
         if ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} !== exp_pins[k] ||
             dram_ba !== exp_ba[k] || dram_addr !== exp_addr[k]) begin
            n_err++;
            $display("FAIL encode_%0d got pins=%b ba=%0d addr=%0h exp pins=%b ba=%0d addr=%0h", k,
                     {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}, dram_ba, dram_addr,
                     exp_pins[k], exp_ba[k], exp_addr[k]);
         end
      end
      sample_at(cyc + 4);
   endtask

   task automatic test_read;
      int n;
      n = cyc + 2;
      at_cycle(n);
      rl_m1 = 4'd4; len = 4'd3; id = 4'd7;
      push_beats(1'b1, n + 6, 4'd7, 4, 1'b1);
      grant(1);
      rl_m1 = 4'd0; len = 4'd9; id = 4'd1;
      sample_at(n + 1);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_early got=%b exp=1", busy); end
      sample_at(n + 9);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_last got=%b exp=1", busy); end
      sample_at(n + 10);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_done got=%b exp=0", busy); end
   endtask

   task automatic test_write;
      int n;
      logic exp_odt;
      n = cyc + 2;
      at_cycle(n);
      wl_m1 = 4'd2; len = 4'd1; id = 4'd3;
      push_beats(1'b0, n + 4, 4'd3, 2, 1'b1);
      grant(2);
      wl_m1 = 4'd9;
      for (int c = n + 1; c <= n + 8; c++) begin
         sample_at(c);
`ifdef SAL_CMD_GEN_ODT_EN
         exp_odt = (c <= n + 6);
`else
         exp_odt = 1'b0;
`endif
         n_cmp++;
         if (dram_odt !== exp_odt) begin
            n_err++;
            $display("FAIL wr_odt cyc=%0d got=%b exp=%b", c, dram_odt, exp_odt);
         end
      end
   endtask

   task automatic test_back_to_back;
      int n;
      n = cyc + 2;
      at_cycle(n);
      rl_m1 = 4'd2; len = 4'd1; id = 4'd1;
      push_beats(1'b1, n + 4, 4'd1, 2, 1'b1);
      push_beats(1'b1, n + 6, 4'd2, 2, 1'b1);
      grant(1);
      at_cycle(n + 2);
      id = 4'd2;
      grant(1);
      sample_at(n + 9);
      n_cmp++;
      if (err_overlap !== 1'b0) begin n_err++; $display("FAIL b2b_no_overlap got=%b exp=0", err_overlap); end
   endtask

   task automatic test_overlap;
      int n;
      n = cyc + 2;
      at_cycle(n);
      rl_m1 = 4'd0; len = 4'd7; id = 4'd4;
      push_beats(1'b1, n + 2, 4'd4, 2, 1'b0);
      push_beats(1'b1, n + 4, 4'd5, 3, 1'b1);
      grant(1);
      at_cycle(n + 2);
      len = 4'd2; id = 4'd5;
      grant(1);
      sample_at(n + 3);
      n_cmp++;
      if (err_overlap !== 1'b0) begin n_err++; $display("FAIL ovl_before got=%b exp=0", err_overlap); end
      sample_at(n + 4);
      n_cmp++;
      if (err_overlap !== 1'b1) begin n_err++; $display("FAIL ovl_set got=%b exp=1", err_overlap); end
      sample_at(n + 12);
      n_cmp++;
      if (err_overlap !== 1'b1) begin n_err++; $display("FAIL ovl_sticky got=%b exp=1", err_overlap); end
   endtask

   task automatic test_multi_gnt;
      int n;
      n = cyc + 2;
      at_cycle(n);
      n_cmp++;
      if (err_multi_gnt !== 1'b0) begin n_err++; $display("FAIL multi_before got=%b exp=0", err_multi_gnt); end
      ba = 2'd3; ra = 14'h055; rl_m1 = 4'd0; len = 4'd0;
      rd_gnt = 1'b1;
      grant(0);
      sample_at(n + 1);
      n_cmp++;
      if ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, dram_addr} !== {4'b0011, 2'd3, 14'h055}) begin
         n_err++;
         $display("FAIL multi_act_pins got=%b ba=%0d addr=%0h exp=0011 ba=3 addr=55",
                  {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}, dram_ba, dram_addr);
      end
      n_cmp++;
      if (err_multi_gnt !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL multi_flags got err=%b busy=%b exp err=1 busy=0", err_multi_gnt, busy);
      end
      sample_at(n + 20);
      n_cmp++;
      if (err_multi_gnt !== 1'b1) begin n_err++; $display("FAIL multi_sticky got=%b exp=1", err_multi_gnt); end
   endtask

   task automatic test_reset_mid_burst;
      int n;
      n = cyc + 2;
      at_cycle(n);
      rl_m1 = 4'd4; len = 4'd7; id = 4'd9;
      push_beats(1'b1, n + 6, 4'd9, 3, 1'b0);
      grant(1);
      sample_at(n + 8);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      n_cmp++;
      if ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} !== 4'b0111 || dram_ba !== '0 || dram_addr !== '0) begin
         n_err++;
         $display("FAIL midrst_pins got=%b ba=%0d addr=%0h exp=0111 ba=0 addr=0",
                  {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n}, dram_ba, dram_addr);
      end
      n_cmp++;
      if ({dram_odt, wr_data_en, wr_last, rd_data_en, rd_last, busy, err_multi_gnt, err_overlap} !== 8'h00) begin
         n_err++;
         $display("FAIL midrst_flags got=%b exp=00000000",
                  {dram_odt, wr_data_en, wr_last, rd_data_en, rd_last, busy, err_multi_gnt, err_overlap});
      end
      n_cmp++;
      if ({wr_id, rd_id} !== '0) begin
         n_err++;
         $display("FAIL midrst_ids got wr=%0d rd=%0d exp 0/0", wr_id, rd_id);
      end
      repeat (3) @(negedge clk);
      rd_q.delete();
      wr_q.delete();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (25) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy_after got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_act();
      test_encoding();
      test_read();
      test_write();
      test_back_to_back();
      test_overlap();
      test_multi_gnt();
      test_reset_mid_burst();
      n_cmp++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got rd=%0d wr=%0d exp 0/0", rd_q.size(), wr_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sal_cmd_gen.md
SAL_CMD_GEN -- requirements
Module: sal_cmd_gen

Interface
REQ-001 SHALL have parameter BA_W, default 2, DRAM bank address width.
REQ-002 SHALL have parameter ADDR_W, default 14, DRAM address pin width.
REQ-003 SHALL have parameter CA_W, default 10, column address width, at most 10.
REQ-004 SHALL have parameters ID_W (4), LEN_W (4), LAT_W (4); LEN_W is AXI length width and LAT_W is latency field width.
REQ-005 SHALL have the following ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- act_gnt/rd_gnt/wr_gnt/pre_gnt/ref_gnt  in  1 each  scheduler grants; sink end of SCHED_IF.
- ba  in  BA_W  granted bank.
- ra  in  ADDR_W  row address, ACT only.
- ca  in  CA_W  column address, RD/WR only.
- id  in  ID_W  AXI id, RD/WR only.
- len  in  LEN_W  burst beats minus 1, RD/WR only.
- rl_m1  in  LAT_W  read latency minus 1, clk cycles.
- wl_m1  in  LAT_W  write latency minus 1, clk cycles.
- dram_cs_n/dram_ras_n/dram_cas_n/dram_we_n  out  1 each  DDR2 command pins.
- dram_ba  out  BA_W  bank pins.
- dram_addr  out  ADDR_W  address pins.
- dram_odt  out  1  on-die termination.
- wr_data_en/wr_last  out  1  pop one write beat / final beat.
- wr_id  out  ID_W  id of active write burst.
- rd_data_en/rd_last  out  1  capture one read beat / final beat.
- rd_id  out  ID_W  id of active read burst.
- busy  out  1  descriptor in flight or burst active.
- err_multi_gnt/err_overlap  out  1  sticky errors.

Function
REQ-006 SHALL register all pin outputs; a grant at cycle N appears on pins at N+1.
REQ-007 SHALL encode {cs_n,ras_n,cas_n,we_n}: ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, NOP 0111.
REQ-008 SHALL drive addr=ra for ACT; addr[CA_W-1:0]=ca with A10=0 and other bits 0 for RD/WR; addr=0 for PRE and REF.
REQ-009 SHALL drive ba for ACT/RD/WR/PRE, and ba=0 for REF and NOP.
REQ-010 SHALL resolve multiple grants in one cycle by priority ACT>RD>WR>PRE>REF, drop the rest, and set err_multi_gnt.
REQ-011 SHALL, per RD grant at N, capture {id,len,rl_m1} into a latency pipeline (depth 2^LAT_W) so rd_data_en first asserts at N+2+rl_m1; same for WR with wl_m1 and wr_data_en.
REQ-012 SHALL assert rd_data_en for len+1 consecutive cycles with rd_id constant; rd_last SHALL be on the final beat only. Writes behave identically.
REQ-013 SHALL sample latency per command; later changes to rl_m1/wl_m1 SHALL not affect in-flight descriptors.
REQ-014 SHALL, when a new burst starts while the same-direction burst is active, set err_overlap, abort the old burst without asserting its last, and start the new one.
REQ-015 SHALL allow back-to-back bursts (new start the cycle after last) with no gap and no error.
REQ-016 SHALL assert busy whenever any pipeline stage is valid or either burst is active.

Reset
REQ-017 SHALL, on rst_n low at any time, immediately force pins to NOP, ba/addr to 0, odt/data enables/last/ids/busy/errors to 0, and clear the pipelines and bursts.
REQ-018 SHALL clear errors only by reset.

Configuration
REQ-019 SHALL, with SAL_CMD_GEN_ODT_EN defined, assert dram_odt from the WR command-pin cycle through the wr_last cycle+1; without it, dram_odt SHALL be constant 0.

Structure
REQ-020 SHALL place the command enum, pin-encoding constants, and the burst descriptor struct {id,len} in shared package sal_cmd_pkg.
REQ-021 SHALL implement the pipeline plus beat counter as sub-module sal_burst_engine, instantiated once for reads and once for writes.

Verification
REQ-022 ACT gnt cycle 5, ba=2, ra=0x1A3 -> cycle 6 pins 0011, dram_ba=2, addr=0x1A3; cycle 7 NOP.
REQ-023 RD gnt cycle 10, rl_m1=4, len=3, id=7 -> rd_data_en cycles 16-19, rd_id=7, rd_last cycle 19, busy low cycle 20.
REQ-024 WR gnt cycle 20, wl_m1=2, len=1 -> wr_data_en 24-25, wr_last 25; with ODT_EN, odt cycles 21-26.
REQ-025 act_gnt+rd_gnt same cycle -> ACT on pins, no read burst, err_multi_gnt=1 until reset.
REQ-026 RD len=7 at cycle 0, RD at cycle 2, rl_m1=0 -> second burst starts cycle 4, err_overlap=1, no rd_last for first burst.
REQ-027 rst_n low mid-burst cycle 17 -> same cycle all outputs reset values, no further data enables after release.
